// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester's access port (request/grant, write data, routed read data)
interface mem_port_arbiter_if #(
  parameter int ADDRESS_SIZE = 9,
  parameter int DATA_WIDTH = 32
);
  logic req, we, lock, gnt, rvalid;
  logic [ADDRESS_SIZE-1:0] addr;
  logic [DATA_WIDTH-1:0] din, dout;
  modport master (output req, we, lock, addr, din, input gnt, rvalid, dout);
  modport slave (input req, we, lock, addr, din, output gnt, rvalid, dout);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin host/engine arbiter for the single-port matrix memory with burst locks.
// Optional burst cap (forced lock release after MAX_BURST grants) enabled by MEM_ARB_BURST_CAP_EN.
module mem_port_arbiter #(
  parameter int ADDRESS_SIZE = 9,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_port_arbiter_if.slave       h,
  mem_port_arbiter_if.slave       e,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [DATA_WIDTH-1:0]   mem_dout,
  output logic                    lock_break
);
  typedef enum logic [1:0] {NONE, OWN_H, OWN_E} owner_t;
  owner_t owner_q, owner_d, owner_fsm;
  logic last_e_q, rd_e_q, acc, we_sel;
  logic [ADDRESS_SIZE-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_din_q;
  logic mem_read_q, mem_write_q;
  logic [RD_LATENCY-1:0] tag_v_q, tag_e_q;
  if (RD_LATENCY < 1 || RD_LATENCY > 4 || MAX_BURST < 1) begin : g_param_err
    $error("mem_port_arbiter: RD_LATENCY must be 1..4 and MAX_BURST >= 1");
  end
  // last_e_q breaks ties: whoever was served last yields
  assign h.gnt = owner_q == OWN_H ? h.req : owner_q == OWN_E ? 1'b0 : h.req & (~e.req | last_e_q);
  assign e.gnt = owner_q == OWN_E ? e.req : owner_q == OWN_H ? 1'b0 : e.req & (~h.req | ~last_e_q);
  assign acc = h.gnt | e.gnt;
  assign we_sel = e.gnt ? e.we : h.we;
  always_comb begin
    owner_fsm = owner_q;
    unique case (owner_q)
      NONE:    owner_fsm = (h.gnt & h.lock) ? OWN_H : (e.gnt & e.lock) ? OWN_E : NONE;
      OWN_H:   owner_fsm = h.gnt ? (h.lock ? OWN_H : NONE) : (~h.req & ~h.lock) ? NONE : OWN_H;
      OWN_E:   owner_fsm = e.gnt ? (e.lock ? OWN_E : NONE) : (~e.req & ~e.lock) ? NONE : OWN_E;
      default: owner_fsm = NONE;
    endcase
  end
`ifdef MEM_ARB_BURST_CAP_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic own_gnt, oth_req, brk, lock_break_q;
  // the grant that completes MAX_BURST releases the lock at the same edge if the other side waits
  always_comb begin
    own_gnt = owner_q == OWN_H ? h.gnt : owner_q == OWN_E ? e.gnt : 1'b0;
    oth_req = owner_q == OWN_H ? e.req : h.req;
    brk = own_gnt & oth_req & (owner_fsm != NONE) & (int'(cnt_q) >= MAX_BURST - 1);
    owner_d = brk ? NONE : owner_fsm;
    cnt_d = owner_d == NONE ? '0 : owner_d != owner_q ? CW'(1) :
            (own_gnt & (int'(cnt_q) < MAX_BURST)) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      lock_break_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lock_break_q <= brk;
    end
  assign lock_break = lock_break_q;
`else
  assign owner_d = owner_fsm;
  assign lock_break = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner_q <= NONE;
      last_e_q <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      rd_e_q <= 1'b0;
      tag_v_q <= '0;
      tag_e_q <= '0;
    end else begin
      owner_q <= owner_d;
      mem_read_q <= acc & ~we_sel;
      mem_write_q <= acc & we_sel;
      if (acc) begin
        last_e_q <= e.gnt;
        rd_e_q <= e.gnt;
        mem_addr_q <= e.gnt ? e.addr : h.addr;
        mem_din_q <= e.gnt ? e.din : h.din;
      end
      tag_v_q <= RD_LATENCY'({tag_v_q, mem_read_q});
      tag_e_q <= RD_LATENCY'({tag_e_q, rd_e_q});
    end
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
  assign mem_read = mem_read_q;
  assign mem_write = mem_write_q;
  assign h.rvalid = tag_v_q[RD_LATENCY-1] & ~tag_e_q[RD_LATENCY-1];
  assign e.rvalid = tag_v_q[RD_LATENCY-1] & tag_e_q[RD_LATENCY-1];
  assign h.dout = h.rvalid ? mem_dout : '0;
  assign e.dout = e.rvalid ? mem_dout : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a command/read-data scoreboard checked by a negedge monitor.
module tb_mem_port_arbiter;
  localparam int AW = 9, DW = 32, L = 2;
`ifdef MEM_ARB_BURST_CAP_EN
  localparam int MB = 4;
`else
  localparam int MB = 16;
`endif
  typedef struct {bit e; bit we; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
  typedef struct {int cyc; logic [DW-1:0] data;} rd_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic mem_read, mem_write, lock_break;
  mem_port_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW)) h_if ();
  mem_port_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW)) e_if ();
  mem_port_arbiter #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .RD_LATENCY(L), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .h(h_if), .e(e_if),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
    .mem_dout(mem_dout), .lock_break(lock_break)
  );
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_pipe [L];
  cmd_t cmdq [$];
  rd_t hq [$], eq [$];
  int n_checks = 0, n_fail = 0, cyc = 0, lb_cnt = 0, lb_cyc = -1, rv_cnt = 0;
  bit in_reset = 1'b1;
  always #5 clk = ~clk;
  // memory model: data for a read-strobe cycle appears L cycles later
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) mem[mem_addr] <= mem_din;
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[L-1];
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic void exp_cmd(bit e, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    cmd_t c;
    c.e = e; c.we = we; c.addr = a; c.data = d;
    cmdq.push_back(c);
  endfunction
  always @(negedge clk) begin : mon
    cmd_t c;
    rd_t r;
    if (!in_reset) begin
      if (lock_break) begin
        lb_cnt++;
        lb_cyc = cyc;
      end
      rv_cnt += int'(h_if.rvalid) + int'(e_if.rvalid);
      if (mem_read || mem_write) begin
        check("cmd_expected", 64'(cmdq.size() != 0), 1);
        if (cmdq.size() != 0) begin
          c = cmdq.pop_front();
          check("cmd_write", mem_write, c.we);
          check("cmd_read", mem_read, !c.we);
          check("cmd_addr", mem_addr, c.addr);
          r.cyc = cyc + L;
          r.data = c.data;
          if (c.we) check("cmd_din", mem_din, c.data);
          else if (c.e) eq.push_back(r);
          else hq.push_back(r);
        end
      end
      if (h_if.rvalid) begin
        check("h_rvalid_expected", 64'(hq.size() != 0), 1);
        if (hq.size() != 0) begin
          r = hq.pop_front();
          check("h_rvalid_cycle", cyc, r.cyc);
          check("h_dout", h_if.dout, r.data);
        end
      end else check("h_dout_idle", h_if.dout, 0);
      if (e_if.rvalid) begin
        check("e_rvalid_expected", 64'(eq.size() != 0), 1);
        if (eq.size() != 0) begin
          r = eq.pop_front();
          check("e_rvalid_cycle", cyc, r.cyc);
          check("e_dout", e_if.dout, r.data);
        end
      end else check("e_dout_idle", e_if.dout, 0);
    end
  end
  task automatic issue(input bit e, input bit we, input bit lock, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int acc);
    bit g;
    int n = 0;
    acc = -1;
    if (e) begin
      e_if.req = 1'b1; e_if.we = we; e_if.lock = lock; e_if.addr = a; e_if.din = d;
    end else begin
      h_if.req = 1'b1; h_if.we = we; h_if.lock = lock; h_if.addr = a; h_if.din = d;
    end
    while (acc < 0 && n < 200) begin
      @(negedge clk);
      g = e ? e_if.gnt : h_if.gnt;
      @(posedge clk);
      #1;
      n++;
      if (g) acc = cyc;
    end
    check(e ? "e_grant_timeout" : "h_grant_timeout", 64'(acc >= 0), 1);
    if (e) e_if.req = 1'b0;
    else h_if.req = 1'b0;
  endtask
  task automatic burst(input bit e, input int n, input logic [AW-1:0] base, output int first, output int last);
    int a;
    first = -1;
    last = -1;
    for (int i = 0; i < n; i++) begin
      issue(e, 1'b0, i < n - 1, base + AW'(i), '0, a);
      if (i == 0) first = a;
      last = a;
    end
  endtask
  initial begin
    int ah, ae, ef, el, rv0;
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
    {h_if.req, h_if.we, h_if.lock, h_if.addr, h_if.din} = '0;
    {e_if.req, e_if.we, e_if.lock, e_if.addr, e_if.din} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_mem_rw", {mem_read, mem_write}, 0);
    check("rst_lock_break", lock_break, 0);
    check("rst_rvalid", {h_if.rvalid, e_if.rvalid}, 0);
    reset = 1'b1;
    in_reset = 1'b0;
    @(posedge clk);
    #1;
    // tie right after reset: H first, then E, back-to-back reads with alternating tags
    exp_cmd(0, 0, 9'h0AA, 32'h0AA);
    exp_cmd(1, 0, 9'h055, 32'h055);
    fork
      issue(0, 0, 0, 9'h0AA, '0, ah);
      issue(1, 0, 0, 9'h055, '0, ae);
    join
    check("tie_e_after_h", 64'(ae - ah), 1);
    exp_cmd(0, 0, 9'h001, 32'h1);
    issue(0, 0, 0, 9'h001, '0, ah);
    exp_cmd(0, 1, 9'h000, 32'h8000_0000);
    issue(0, 1, 0, 9'h000, 32'h8000_0000, ah);
    exp_cmd(1, 0, 9'h000, 32'h8000_0000);
    issue(1, 0, 0, 9'h000, '0, ae);
    check("write_then_read_b2b", 64'(ae - ah), 1);
    repeat (L + 2) @(posedge clk);
    #1;
`ifdef MEM_ARB_BURST_CAP_EN
    for (int i = 0; i < 4; i++) exp_cmd(1, 0, 9'h020 + AW'(i), 32'h020 + DW'(i));
    exp_cmd(0, 0, 9'h1F0, 32'h1F0);
    for (int i = 4; i < 10; i++) exp_cmd(1, 0, 9'h020 + AW'(i), 32'h020 + DW'(i));
    fork
      burst(1, 10, 9'h020, ef, el);
      begin
        @(posedge clk);
        #1;
        issue(0, 0, 0, 9'h1F0, '0, ah);
      end
    join
    check("cap_h_slot", 64'(ah - ef), 4);
    check("cap_e_resumes", 64'(el - ef), 10);
    check("cap_break_cycle", 64'(lb_cyc - ef), 3);
    check("cap_break_count", 64'(lb_cnt), 1);
`else
    for (int i = 0; i < 16; i++) exp_cmd(1, 0, 9'h010 + AW'(i), 32'h010 + DW'(i));
    exp_cmd(0, 0, 9'h1F0, 32'h1F0);
    fork
      burst(1, 16, 9'h010, ef, el);
      begin
        @(posedge clk);
        #1;
        issue(0, 0, 0, 9'h1F0, '0, ah);
      end
    join
    check("lock_burst_len", 64'(el - ef), 15);
    check("lock_h_after_burst", 64'(ah - el), 1);
    check("lock_no_break", 64'(lb_cnt), 0);
`endif
    repeat (L + 3) @(posedge clk);
    #1;
    // short reset while a read is in flight must kill its rvalid
    exp_cmd(1, 0, 9'h012, 32'h012);
    issue(1, 0, 0, 9'h012, '0, ae);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_reset = 1'b1;
    hq.delete();
    eq.delete();
    #1;
    check("rst2_mem_addr", mem_addr, 0);
    check("rst2_mem_rw", {mem_read, mem_write}, 0);
    check("rst2_rvalid_dout", {h_if.rvalid, e_if.rvalid, h_if.dout, e_if.dout}, 0);
    check("rst2_lock_break", lock_break, 0);
    #1;
    reset = 1'b1;
    in_reset = 1'b0;
    rv0 = rv_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("no_rvalid_after_reset", 64'(rv_cnt - rv0), 0);
    check("cmdq_drained", 64'(cmdq.size()), 0);
    check("hq_drained", 64'(hq.size()), 0);
    check("eq_drained", 64'(eq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port matrix memory (status, config, A/B/C regions) between two requesters: the external host loader (port H) and the matrix engine controller (port E).
- Round-robin arbitration with an optional burst lock, so the engine can stream a 4x4 block without interleaving.
- Registers the memory command and routes returned read data to the requester that issued the read.
- Sits between both requesters and the memory instance.

Parameters:
- ADDRESS_SIZE, 9, memory address width.
- DATA_WIDTH, 32, memory word width.
- RD_LATENCY, 1, cycles from mem_read-high cycle to valid mem_dout (1..4).
- MAX_BURST, 16, consecutive locked grants before a forced release (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- h_req  in  1  host access request.
- h_we  in  1  host access is a write when 1.
- h_lock  in  1  host requests ownership after this grant.
- h_addr  in  ADDRESS_SIZE  host address.
- h_din  in  DATA_WIDTH  host write data.
- h_gnt  out  1  host request accepted this cycle (combinational).
- h_rvalid  out  1  host read data valid.
- h_dout  out  DATA_WIDTH  host read data.
- e_req, e_we, e_lock, e_addr, e_din, e_gnt, e_rvalid, e_dout: same as the h_* ports, for the engine.
- mem_addr  out  ADDRESS_SIZE  registered memory address.
- mem_din  out  DATA_WIDTH  registered memory write data.
- mem_read  out  1  registered memory read strobe.
- mem_write  out  1  registered memory write enable.
- mem_dout  in  DATA_WIDTH  memory read data.
- lock_break  out  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset (reset=0, asynchronous): all of the following clear immediately.
  - mem_addr=0, mem_din=0, mem_read=0, mem_write=0, lock_break=0.
  - h_rvalid=e_rvalid=0.
  - owner=NONE, last_served=E (so H wins the first tie), burst count=0.
  - Read-tag pipeline cleared; in-flight reads are dropped and no rvalid appears after reset releases.
- Request rules:
  - A requester holds req/we/addr/din/lock stable until it sees gnt=1.
  - Acceptance occurs at the rising edge where req=1 and gnt=1. The requester may present its next request in the following cycle, giving 1 access/cycle throughput.
- Grant, combinational from registered state:
  - owner=H: h_gnt=h_req, e_gnt=0. owner=E: mirror image.
  - owner=NONE, one requester active: that requester is granted.
  - owner=NONE, both active: the requester not equal to last_served is granted.
  - Never both gnt=1 in the same cycle.
- On an accepted request at edge k:
  - mem_addr, mem_din, mem_write=we, mem_read=~we are registered and held for exactly cycle k+1.
  - last_served is set to the granted requester.
- Cycles with no acceptance: mem_read=mem_write=0; mem_addr and mem_din hold their last values.
- Read return:
  - A tag (H/E, valid) shifts through an RD_LATENCY-deep pipeline.
  - x_rvalid=1 for exactly one cycle, RD_LATENCY cycles after the mem_read-high cycle, with x_dout=mem_dout in that cycle.
  - x_dout=0 when x_rvalid=0.
  - Writes generate no rvalid.
- Lock state machine (NONE / OWN_H / OWN_E):
  - NONE -> OWN_x on an accepted x request with x_lock=1.
  - OWN_x -> OWN_x on an accepted x request with x_lock=1.
  - OWN_x -> NONE on an accepted x request with x_lock=0 (final beat), or when x_req=0 and x_lock=0 in any cycle.
  - The owner may idle while holding x_lock=1; the other requester stays blocked.
- Simultaneous read return and a new grant: independent, both proceed in the same cycle.
- Back-to-back reads from alternating requesters: tags keep order, and each rvalid goes to the correct port.

Optional Feature:
- Macro: MEM_ARB_BURST_CAP_EN.
- With the macro defined:
  - A counter counts consecutive accepted grants while owner=x.
  - When the count reaches MAX_BURST and the other requester has req=1, the next edge forces owner=NONE and pulses lock_break=1 for one cycle.
  - The other requester is then granted by round-robin. The counter clears on any ownership change.
- Without the macro: no counter, locks are unlimited, and lock_break is tied to 0.

Test Plan:
- Reset mid-read: E reads addr 0x12 with RD_LATENCY=2; reset is asserted one cycle after the grant -> all outputs are 0, and no e_rvalid appears after reset releases.
- Tie after reset: h_req=e_req=1 in the same cycle -> H granted first, then E the next cycle; mem_addr sequence is h_addr then e_addr.
- Read routing: H reads addr 0x001, memory returns 0x00000001 -> h_rvalid=1 exactly RD_LATENCY cycles after mem_read, h_dout=0x00000001, e_rvalid=0.
- Lock burst: E issues 16 reads with e_lock=1 and final beat e_lock=0 from 0x010 while h_req=1 throughout -> h_gnt=0 for all 16 beats, then H is granted the next cycle.
- Write path: H writes 0x80000000 to addr 0 -> mem_write=1, mem_addr=0, mem_din=0x80000000 for one cycle; no rvalid.
- MEM_ARB_BURST_CAP_EN, MAX_BURST=4: E holds lock for 10 beats while H requests -> lock_break pulses after the 4th E grant, H is granted once, then E resumes.
